// File: rtl/data_sync_hs.sv
// data_sync_hs: destination-side receiver for a multi-bit clock-domain crossing.
// A slow qualifier (level or toggle) is synchronised through a flop chain. The
// quasi-static source bus is captured only on the detected qualifier event and
// is then presented through a one-entry valid/ready holding register. A toggle
// acknowledge goes back to the source domain, and a sticky overrun flag reports
// events that arrived while the holding register was still full.
module data_sync_hs #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int MODE       = 0,
  parameter int OVERWRITE  = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] Unsync_bus,
  input  logic                 bus_enable,
  input  logic                 sync_ready,
  input  logic                 clr_overrun,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 enable_pulse,
  output logic                 ack_toggle,
  output logic                 overrun
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_STAGES-1:0] sync_ff;
  logic                  sync_prev;
  logic                  sync_level;
  logic                  event_det;
  logic                  capture;
  logic                  overrun_set;

  // Qualifier synchroniser chain plus one extra flop used for edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_ff   <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[NUM_STAGES-2:0], bus_enable};
      sync_prev <= sync_ff[NUM_STAGES-1];
    end
  end

  assign sync_level = sync_ff[NUM_STAGES-1];

  // Level mode reacts to a rising edge only; toggle mode reacts to either edge.
  generate
    if (MODE == 1) begin : g_toggle_mode
      assign event_det = sync_level ^ sync_prev;
    end else begin : g_level_mode
      assign event_det = sync_level & ~sync_prev;
    end
  endgenerate

  // Holding-register state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Decide whether this cycle captures, drains or flags an overrun.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (event_det) begin
          capture = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (sync_ready && !event_det) begin
          state_d = EMPTY;
        end else if (sync_ready && event_det) begin
          capture = 1'b1;
        end else if (event_det) begin
          overrun_set = 1'b1;
          capture     = (OVERWRITE != 0);
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // The source bus is sampled only on a capture edge, never through a flop chain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      ack_toggle   <= 1'b0;
    end else begin
      enable_pulse <= capture;
      if (capture) begin
        sync_bus   <= Unsync_bus;
        ack_toggle <= ~ack_toggle;
      end
    end
  end

  // Sticky overrun; a new overrun in the same cycle wins over the clear request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign sync_valid = (state_q == FULL);

endmodule
